reg_file_16x16: RTL and testbench
=================================

# reg_file_16x16

Sixteen-entry, 16-bit general-purpose register file with two combinational read ports, one clocked write port, same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection. Sits between decode (source/destination register IDs) and execute/writeback. Consumes the one-hot read/write wordline scheme produced by the 4-to-16 decoders in the decode stage. Register 0 is hardwired to zero.

## Interface
- NUM_REGS, 16, number of architectural registers (fixed at 16; ID width 4)
- DATA_W, 16, register width in bits

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- SrcReg1  in  4  read port 1 register ID
- SrcReg2  in  4  read port 2 register ID
- SrcData1  out  16  read port 1 data (combinational)
- SrcData2  out  16  read port 2 data (combinational)
- WriteReg  in  1  write enable for writeback
- DstReg  in  4  writeback register ID
- DstData  in  16  writeback data
- MarkBusy  in  1  decode issues an instruction that will write BusyReg
- BusyReg  in  4  register ID to mark busy
- Src1Busy  out  1  SrcReg1 has an outstanding, unbypassed writer
- Src2Busy  out  1  SrcReg2 has an outstanding, unbypassed writer

## Operation
- Storage: regs[1..15] x 16 bits; busy[1..15] x 1 bit. R0 has no storage: reads 16'h0000, never busy, writes and MarkBusy to R0 ignored.
- Write: on rising clk with WriteReg=1 and DstReg!=0, regs[DstReg] <= DstData; busy[DstReg] <= 0 (unless set by MarkBusy the same cycle, see below).
- Read: SrcDataN = 0 if SrcRegN==0; else DstData if WriteReg && DstReg==SrcRegN; else regs[SrcRegN]. Both ports independent; both may bypass at once.
- Scoreboard: on rising clk with MarkBusy=1 and BusyReg!=0, busy[BusyReg] <= 1.
- Simultaneous WriteReg and MarkBusy to same register: data written, busy ends 1 (new producer wins).
- SrcNBusy = busy[SrcRegN] && !(WriteReg && DstReg==SrcRegN); 0 for R0.
- At most one outstanding writer per register; stall logic upstream guarantees this. A second MarkBusy on an already-busy register leaves it busy (no count).
- WriteReg on a non-busy register is legal: data written, busy stays 0.

## Timing
- Reset (rst_n=0, asynchronous): all regs <= 16'h0000, all busy <= 0. Outputs then: SrcData1/2 = 0, Src1Busy/Src2Busy = 0. Reset mid-write: write lost, register reads 0.
- Read latency 0 cycles (combinational from SrcReg, DstReg, DstData, WriteReg, state).
- Write latency 1 edge: value visible from stored array the cycle after the edge; visible via bypass in the write cycle itself.
- Busy set visible on Src*Busy the cycle after MarkBusy edge; busy clear effectively visible in the writeback cycle (bypass masks it).
- No handshake; every input sampled every cycle.

## Structure
- Package reg_file_pkg: REG_ID_W=4, DATA_W=16, NUM_REGS=16, typedef reg_id_t (4-bit), typedef reg_data_t (16-bit), constant ZERO_REG=4'h0.
- One sub-module: write_decoder_4_16 (RegId, WriteReg in; 16-bit one-hot Wordline out, all zero when WriteReg=0). Instantiated twice: writeback data enable and MarkBusy enable. Read side uses one-hot read wordlines muxing regs.

## Test plan
- Reset: hold rst_n=0 with WriteReg=1, DstReg=3, DstData=16'hBEEF, clock twice -> SrcReg1=3 reads 16'h0000, Src1Busy=0 after release.
- Write/read: write R5=16'h1234, next cycle SrcReg1=5, SrcReg2=5 -> both 16'h1234; write R0=16'hFFFF -> SrcReg1=0 reads 16'h0000.
- Bypass: regs[7]=16'h0001, same cycle WriteReg=1, DstReg=7, DstData=16'hA5A5, SrcReg2=7 -> SrcData2=16'hA5A5 before edge, stored after.
- Scoreboard: MarkBusy R9 -> next cycle SrcReg1=9 gives Src1Busy=1; writeback R9 cycle -> Src1Busy=0 and SrcData1=DstData; following cycle busy[9]=0.
- Collision: WriteReg and MarkBusy both to R4, DstData=16'h0042 -> next cycle SrcData1=16'h0042, Src1Busy=1.
- Async reset mid-operation: busy[2]=1, regs[2]=16'h7777, drop rst_n between edges -> SrcData1=0, Src1Busy=0 immediately, no clock required.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, ID/data types and the hardwired-zero register ID for the
// 16x16 register file.
package reg_file_pkg;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   reg_data_t;

    localparam reg_id_t ZERO_REG = 4'h0;

endpackage

// File: rtl/write_decoder_4_16.sv
// 4-to-16 one-hot wordline decoder with enable; all wordlines low when the
// enable is deasserted.
module write_decoder_4_16
   import reg_file_pkg::*;
(
   input  reg_id_t             RegId,
   input  logic                WriteReg,
   output logic [NUM_REGS-1:0] Wordline
);

   // Raise exactly the wordline selected by RegId while the enable is high;
   // with the enable low every wordline stays low.
   always_comb begin
      Wordline = '0;
      if (WriteReg) begin
         Wordline = NUM_REGS'(1) << RegId;
      end
   end

endmodule

// File: rtl/reg_file_16x16.sv
// 16-entry x 16-bit register file: two combinational read ports with
// write-to-read bypass, one clocked write port and a per-register busy scoreboard.
module reg_file_16x16
    import reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_id_t   SrcReg1,
    input  reg_id_t   SrcReg2,
    output reg_data_t SrcData1,
    output reg_data_t SrcData2,
    input  logic      WriteReg,
    input  reg_id_t   DstReg,
    input  reg_data_t DstData,
    input  logic      MarkBusy,
    input  reg_id_t   BusyReg,
    output logic      Src1Busy,
    output logic      Src2Busy
);

    reg_data_t           regs_q [1:NUM_REGS-1];
    reg_data_t           regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;

    logic [NUM_REGS-1:0] wrLine;
    logic [NUM_REGS-1:0] busyLine;
    logic [NUM_REGS-1:0] rdLine1;
    logic [NUM_REGS-1:0] rdLine2;
    logic [NUM_REGS-1:0] busyFull;
    reg_data_t           stored1;
    reg_data_t           stored2;
    logic                bypass1;
    logic                bypass2;

    write_decoder_4_16 u_wr_dec (
        .RegId   (DstReg),
        .WriteReg(WriteReg),
        .Wordline(wrLine)
    );

    write_decoder_4_16 u_busy_dec (
        .RegId   (BusyReg),
        .WriteReg(MarkBusy),
        .Wordline(busyLine)
    );

    // Wordline bit 0 is never consulted, so R0 writes and MarkBusy fall away.
    // A new producer's MarkBusy wins over the retiring writer's clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wrLine[i]) begin
                regs_d[i] = DstData;
                busy_d[i] = 1'b0;
            end
            if (busyLine[i]) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdLine1  = NUM_REGS'(1) << SrcReg1;
        rdLine2  = NUM_REGS'(1) << SrcReg2;
        busyFull = {busy_q, 1'b0};
        stored1  = '0;
        stored2  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            stored1 = stored1 | ({DATA_W{rdLine1[i]}} & regs_q[i]);
            stored2 = stored2 | ({DATA_W{rdLine2[i]}} & regs_q[i]);
        end
        bypass1  = WriteReg && (DstReg == SrcReg1) && (SrcReg1 != ZERO_REG);
        bypass2  = WriteReg && (DstReg == SrcReg2) && (SrcReg2 != ZERO_REG);
        SrcData1 = bypass1 ? DstData : stored1;
        SrcData2 = bypass2 ? DstData : stored2;
        Src1Busy = (|(rdLine1 & busyFull)) && !bypass1;
        Src2Busy = (|(rdLine2 & busyFull)) && !bypass2;
    end

endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed, table-driven bench for reg_file_16x16 with hand-written
// sequences for reset behaviour.
module tb_reg_file_16x16;
    import reg_file_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_id_t   SrcReg1, SrcReg2, DstReg, BusyReg;
    reg_data_t SrcData1, SrcData2, DstData;
    logic      WriteReg, MarkBusy, Src1Busy, Src2Busy;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic      wr;
        reg_id_t   dst;
        reg_data_t data;
        logic      mark;
        reg_id_t   breg;
        reg_id_t   s1;
        reg_id_t   s2;
        reg_data_t expD1;
        reg_data_t expD2;
        logic      expB1;
        logic      expB2;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    reg_file_16x16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SrcReg1 (SrcReg1),
        .SrcReg2 (SrcReg2),
        .SrcData1(SrcData1),
        .SrcData2(SrcData2),
        .WriteReg(WriteReg),
        .DstReg  (DstReg),
        .DstData (DstData),
        .MarkBusy(MarkBusy),
        .BusyReg (BusyReg),
        .Src1Busy(Src1Busy),
        .Src2Busy(Src2Busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic wr, reg_id_t dst, reg_data_t data,
                                   logic mark, reg_id_t breg, reg_id_t s1, reg_id_t s2,
                                   reg_data_t d1, reg_data_t d2, logic b1, logic b2);
        vec_t v;
        v.wr = wr; v.dst = dst; v.data = data; v.mark = mark; v.breg = breg;
        v.s1 = s1; v.s2 = s2; v.expD1 = d1; v.expD2 = d2; v.expB1 = b1; v.expB2 = b2;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        WriteReg = v.wr;
        DstReg   = v.dst;
        DstData  = v.data;
        MarkBusy = v.mark;
        BusyReg  = v.breg;
        SrcReg1  = v.s1;
        SrcReg2  = v.s2;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input reg_data_t d1, input reg_data_t d2,
                            input logic b1, input logic b2);
        checkOutput({tag, " SrcData1"}, SrcData1, d1);
        checkOutput({tag, " SrcData2"}, SrcData2, d2);
        checkOutput({tag, " Src1Busy"}, 16'(Src1Busy), 16'(b1));
        checkOutput({tag, " Src2Busy"}, 16'(Src2Busy), 16'(b2));
    endtask

    initial begin
        // Each vector: inputs held for one cycle, outputs checked before the edge.
        vecs[0]  = mkVec(0, 0, 16'h0000, 0, 0, 3, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mkVec(1, 5, 16'h1234, 0, 0, 5, 5, 16'h1234, 16'h1234, 0, 0);
        vecs[2]  = mkVec(0, 0, 16'h0000, 0, 0, 5, 5, 16'h1234, 16'h1234, 0, 0);
        vecs[3]  = mkVec(1, 0, 16'hFFFF, 0, 0, 0, 5, 16'h0000, 16'h1234, 0, 0);
        vecs[4]  = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[5]  = mkVec(1, 7, 16'h0001, 0, 0, 7, 7, 16'h0001, 16'h0001, 0, 0);
        vecs[6]  = mkVec(1, 7, 16'hA5A5, 0, 0, 5, 7, 16'h1234, 16'hA5A5, 0, 0);
        vecs[7]  = mkVec(0, 0, 16'h0000, 0, 0, 7, 7, 16'hA5A5, 16'hA5A5, 0, 0);
        vecs[8]  = mkVec(0, 0, 16'h0000, 1, 9, 9, 9, 16'h0000, 16'h0000, 0, 0);
        vecs[9]  = mkVec(0, 0, 16'h0000, 0, 0, 9, 9, 16'h0000, 16'h0000, 1, 1);
        vecs[10] = mkVec(1, 9, 16'hCAFE, 0, 0, 9, 9, 16'hCAFE, 16'hCAFE, 0, 0);
        vecs[11] = mkVec(0, 0, 16'h0000, 0, 0, 9, 7, 16'hCAFE, 16'hA5A5, 0, 0);
        vecs[12] = mkVec(1, 4, 16'h0042, 1, 4, 4, 9, 16'h0042, 16'hCAFE, 0, 0);
        vecs[13] = mkVec(0, 0, 16'h0000, 0, 0, 4, 4, 16'h0042, 16'h0042, 1, 1);
        vecs[14] = mkVec(0, 0, 16'h0000, 1, 0, 0, 4, 16'h0000, 16'h0042, 0, 1);
        vecs[15] = mkVec(0, 0, 16'h0000, 1, 4, 0, 4, 16'h0000, 16'h0042, 0, 1);
        vecs[16] = mkVec(0, 0, 16'h0000, 0, 0, 4, 0, 16'h0042, 16'h0000, 1, 0);
        vecs[17] = mkVec(1, 4, 16'h0043, 0, 0, 9, 4, 16'hCAFE, 16'h0043, 0, 0);
        vecs[18] = mkVec(0, 0, 16'h0000, 0, 0, 4, 4, 16'h0043, 16'h0043, 0, 0);
        vecs[19] = mkVec(1, 11, 16'h1111, 0, 0, 11, 11, 16'h1111, 16'h1111, 0, 0);
        vecs[20] = mkVec(0, 0, 16'h0000, 0, 0, 11, 1, 16'h1111, 16'h0000, 0, 0);

        // Reset held while a write is presented: the write must be lost.
        rst_n = 1'b0;
        applyStimulus(mkVec(1, 3, 16'hBEEF, 0, 0, 3, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[0]);
        #1;
        checkAll("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].expD1, vecs[i].expD2,
                     vecs[i].expB1, vecs[i].expB2);
        end

        // Async reset between edges with R2 written and marked busy.
        @(negedge clk);
        applyStimulus(mkVec(1, 2, 16'h7777, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        applyStimulus(mkVec(0, 0, 16'h0000, 1, 2, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        applyStimulus(mkVec(0, 0, 16'h0000, 0, 0, 2, 5, 0, 0, 0, 0));
        #1;
        checkAll("preRst", 16'h7777, 16'h1234, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("asyncRst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkVec(0, 0, 16'h0000, 0, 0, 11, 9, 0, 0, 0, 0));
        #1;
        checkAll("postRst", 16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
